// File: rtl/wb_port_arbiter.sv
// Writeback-port arbiter: one held result slot per execution unit, round-robin grant onto a single port.
// Optional conflict counter is compiled in when WB_ARB_PERF_CNT_EN is defined.
module wb_port_arbiter #(
  parameter int NUM_UNITS     = 9,
  parameter int RD_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  localparam int UNIT_W       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                flush,
  input  logic [NUM_UNITS-1:0]                unit_valid,
  output logic [NUM_UNITS-1:0]                unit_ready,
  input  logic [NUM_UNITS*RD_ADDR_WIDTH-1:0]  unit_rd,
  input  logic [NUM_UNITS-1:0]                unit_is_fp,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0]     unit_data,
  input  logic [NUM_UNITS-1:0]                clear_rd,
  output logic                                wb_valid,
  input  logic                                wb_ready,
  output logic [UNIT_W-1:0]                   wb_unit,
  output logic [RD_ADDR_WIDTH-1:0]            wb_rd,
  output logic                                wb_is_fp,
  output logic [DATA_WIDTH-1:0]               wb_data,
  output logic [NUM_UNITS-1:0]                pend_busy,
  output logic [NUM_UNITS*RD_ADDR_WIDTH-1:0]  pend_rd,
  output logic [15:0]                         conflict_cnt
);

  logic [NUM_UNITS-1:0]     slot_valid;
  logic [RD_ADDR_WIDTH-1:0] slot_rd   [NUM_UNITS];
  logic                     slot_is_fp[NUM_UNITS];
  logic [DATA_WIDTH-1:0]    slot_data [NUM_UNITS];

  logic [NUM_UNITS-1:0] eligible;
  logic [NUM_UNITS-1:0] grant;
  logic [UNIT_W-1:0]    grant_idx;
  logic                 grant_found;
  logic [UNIT_W-1:0]    rr_ptr_reg;
  int                   scan_idx;

  assign eligible   = slot_valid & ~clear_rd;
  assign unit_ready = {NUM_UNITS{reset_n}} &
                      (~slot_valid | (grant & {NUM_UNITS{wb_ready & ~flush}}));

  // Scan starts at rr_ptr and wraps; the first eligible slot wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    scan_idx    = 0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      scan_idx = int'(rr_ptr_reg) + k;
      if (scan_idx >= NUM_UNITS) scan_idx = scan_idx - NUM_UNITS;
      if (!grant_found && eligible[scan_idx]) begin
        grant_found        = 1'b1;
        grant_idx          = UNIT_W'(scan_idx);
        grant[scan_idx]    = 1'b1;
      end
    end
  end

  assign wb_valid = grant_found;
  assign wb_unit  = grant_idx;
  assign wb_rd    = grant_found ? slot_rd[grant_idx]    : '0;
  assign wb_is_fp = grant_found ? slot_is_fp[grant_idx] : 1'b0;
  assign wb_data  = grant_found ? slot_data[grant_idx]  : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg <= '0;
    end else if (!flush && grant_found && wb_ready) begin
      rr_ptr_reg <= (grant_idx == UNIT_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_slot
      logic                     valid_reg;
      logic [RD_ADDR_WIDTH-1:0] rd_reg;
      logic                     is_fp_reg;
      logic [DATA_WIDTH-1:0]    data_reg;

      // Priority: flush, then WAW kill (drops any same-cycle capture), then capture, then retire.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_reg <= 1'b0;
          rd_reg    <= '0;
          is_fp_reg <= 1'b0;
          data_reg  <= '0;
        end else if (flush || clear_rd[gi]) begin
          valid_reg <= 1'b0;
        end else if (unit_valid[gi] && unit_ready[gi]) begin
          valid_reg <= 1'b1;
          rd_reg    <= unit_rd[gi*RD_ADDR_WIDTH +: RD_ADDR_WIDTH];
          is_fp_reg <= unit_is_fp[gi];
          data_reg  <= unit_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end else if (grant[gi] && wb_ready) begin
          valid_reg <= 1'b0;
        end
      end

      assign slot_valid[gi] = valid_reg;
      assign slot_rd[gi]    = rd_reg;
      assign slot_is_fp[gi] = is_fp_reg;
      assign slot_data[gi]  = data_reg;
      assign pend_rd[gi*RD_ADDR_WIDTH +: RD_ADDR_WIDTH] = rd_reg;
    end
  endgenerate

  assign pend_busy = slot_valid;

`ifdef WB_ARB_PERF_CNT_EN
  logic        multi_eligible;
  logic [15:0] conflict_cnt_reg;

  // Nonzero after clearing the lowest set bit means at least two slots compete.
  assign multi_eligible = |(eligible & (eligible - 1'b1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_cnt_reg <= 16'h0000;
    end else if (multi_eligible && conflict_cnt_reg != 16'hFFFF) begin
      conflict_cnt_reg <= conflict_cnt_reg + 16'h0001;
    end
  end

  assign conflict_cnt = conflict_cnt_reg;
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: per-cycle vector table plus hand-written reset and counter sequences.
module tb_wb_port_arbiter;
  localparam int N  = 9;
  localparam int RW = 5;
  localparam int DW = 32;

`ifdef WB_ARB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk;
  logic              reset_n;
  logic              flush;
  logic [N-1:0]      unit_valid;
  logic [N-1:0]      unit_ready;
  logic [N*RW-1:0]   unit_rd;
  logic [N-1:0]      unit_is_fp;
  logic [N*DW-1:0]   unit_data;
  logic [N-1:0]      clear_rd;
  logic              wb_valid;
  logic              wb_ready;
  logic [3:0]        wb_unit;
  logic [RW-1:0]     wb_rd;
  logic              wb_is_fp;
  logic [DW-1:0]     wb_data;
  logic [N-1:0]      pend_busy;
  logic [N*RW-1:0]   pend_rd;
  logic [15:0]       conflict_cnt;

  wb_port_arbiter #(.NUM_UNITS(N), .RD_ADDR_WIDTH(RW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .unit_valid(unit_valid), .unit_ready(unit_ready), .unit_rd(unit_rd),
    .unit_is_fp(unit_is_fp), .unit_data(unit_data), .clear_rd(clear_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_unit(wb_unit), .wb_rd(wb_rd),
    .wb_is_fp(wb_is_fp), .wb_data(wb_data), .pend_busy(pend_busy),
    .pend_rd(pend_rd), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] vld;
    logic [N-1:0] clr;
    logic         fl;
    logic         rdy;
    logic         exp_valid;
    logic [3:0]   exp_unit;
    logic [N-1:0] exp_busy;
    logic [N-1:0] exp_ready;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Fixed per-unit result pattern driven onto the unit buses for the whole run.
  function automatic logic [RW-1:0] rd_of(int i);
    return RW'(i + 2);
  endfunction
  function automatic logic fp_of(int i);
    return 1'((i & 1) != 0);
  endfunction
  function automatic logic [DW-1:0] data_of(int i);
    return (i == 3) ? 32'hDEAD_BEEF : 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [N-1:0] vld, input logic [N-1:0] clr, input logic fl,
                     input logic rdy, input logic ev, input logic [3:0] eu,
                     input logic [N-1:0] eb, input logic [N-1:0] er);
    vec_t v;
    v.vld = vld; v.clr = clr; v.fl = fl; v.rdy = rdy;
    v.exp_valid = ev; v.exp_unit = eu; v.exp_busy = eb; v.exp_ready = er;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [N-1:0] vld, input logic [N-1:0] clr,
                       input logic fl, input logic rdy);
    unit_valid = vld;
    clear_rd   = clr;
    flush      = fl;
    wb_ready   = rdy;
  endtask

  initial begin
    logic [N*RW-1:0] rd_mask;
    logic [N*RW-1:0] exp_pend_rd;
    logic [RW-1:0]   exp_rd;
    logic [DW-1:0]   exp_data;
    logic            exp_fp;

    for (int i = 0; i < N; i++) begin
      unit_rd[i*RW +: RW]   = rd_of(i);
      unit_is_fp[i]         = fp_of(i);
      unit_data[i*DW +: DW] = data_of(i);
    end
    reset_n = 1'b0;
    drive('0, '0, 1'b0, 1'b1);

    //    vld    clr    fl    rdy   valid unit busy   ready
    add(9'h000, 9'h000, 1'b0, 1'b1, 1'b0, 0, 9'h000, 9'h1FF); // 0 idle
    add(9'h105, 9'h000, 1'b0, 1'b1, 1'b0, 0, 9'h000, 9'h1FF); // 1 capture 0,2,8
    add(9'h000, 9'h000, 1'b0, 1'b1, 1'b1, 0, 9'h105, 9'h0FB); // 2 grant 0
    add(9'h000, 9'h000, 1'b0, 1'b1, 1'b1, 2, 9'h104, 9'h0FF); // 3 grant 2
    add(9'h000, 9'h000, 1'b0, 1'b1, 1'b1, 8, 9'h100, 9'h1FF); // 4 grant 8, rr wraps
    add(9'h008, 9'h000, 1'b0, 1'b1, 1'b0, 0, 9'h000, 9'h1FF); // 5 capture 3
    add(9'h000, 9'h000, 1'b0, 1'b1, 1'b1, 3, 9'h008, 9'h1FF); // 6 grant 3, rr=4
    add(9'h002, 9'h000, 1'b0, 1'b1, 1'b0, 0, 9'h000, 9'h1FF); // 7 capture 1
    add(9'h000, 9'h000, 1'b0, 1'b0, 1'b1, 1, 9'h002, 9'h1FD); // 8  stall
    add(9'h000, 9'h000, 1'b0, 1'b0, 1'b1, 1, 9'h002, 9'h1FD); // 9  stall
    add(9'h000, 9'h000, 1'b0, 1'b0, 1'b1, 1, 9'h002, 9'h1FD); // 10 stall
    add(9'h000, 9'h000, 1'b0, 1'b0, 1'b1, 1, 9'h002, 9'h1FD); // 11 stall
    add(9'h000, 9'h000, 1'b0, 1'b1, 1'b1, 1, 9'h002, 9'h1FF); // 12 retire 1, rr=2
    add(9'h001, 9'h000, 1'b0, 1'b1, 1'b0, 0, 9'h000, 9'h1FF); // 13 capture 0
    add(9'h000, 9'h000, 1'b0, 1'b1, 1'b1, 0, 9'h001, 9'h1FF); // 14 retire 0, rr=1
    add(9'h006, 9'h000, 1'b0, 1'b0, 1'b0, 0, 9'h000, 9'h1FF); // 15 capture 1,2
    add(9'h000, 9'h002, 1'b0, 1'b1, 1'b1, 2, 9'h006, 9'h1FD); // 16 kill 1, grant 2
    add(9'h000, 9'h000, 1'b0, 1'b1, 1'b0, 0, 9'h000, 9'h1FF); // 17 slot 1 gone
    add(9'h010, 9'h010, 1'b0, 1'b1, 1'b0, 0, 9'h000, 9'h1FF); // 18 capture+kill unit 4
    add(9'h000, 9'h000, 1'b0, 1'b1, 1'b0, 0, 9'h000, 9'h1FF); // 19 nothing held
    add(9'h020, 9'h000, 1'b0, 1'b1, 1'b0, 0, 9'h000, 9'h1FF); // 20 capture 5
    add(9'h020, 9'h000, 1'b0, 1'b1, 1'b1, 5, 9'h020, 9'h1FF); // 21 back-to-back
    add(9'h000, 9'h000, 1'b0, 1'b1, 1'b1, 5, 9'h020, 9'h1FF); // 22 second result
    add(9'h000, 9'h000, 1'b0, 1'b1, 1'b0, 0, 9'h000, 9'h1FF); // 23 empty, rr=6
    add(9'h0C7, 9'h000, 1'b0, 1'b0, 1'b0, 0, 9'h000, 9'h1FF); // 24 capture 5 units
    add(9'h100, 9'h000, 1'b1, 1'b1, 1'b1, 6, 9'h0C7, 9'h138); // 25 flush
    add(9'h000, 9'h000, 1'b0, 1'b1, 1'b0, 0, 9'h000, 9'h1FF); // 26 all dropped
    add(9'h060, 9'h000, 1'b0, 1'b1, 1'b0, 0, 9'h000, 9'h1FF); // 27 capture 5,6
    add(9'h000, 9'h000, 1'b0, 1'b1, 1'b1, 6, 9'h060, 9'h1DF); // 28 rr still 6
    add(9'h000, 9'h000, 1'b0, 1'b1, 1'b1, 5, 9'h020, 9'h1FF); // 29
    add(9'h000, 9'h000, 1'b0, 1'b1, 1'b0, 0, 9'h000, 9'h1FF); // 30

    repeat (2) @(negedge clk);
    #1;
    chk("reset_unit_ready", 64'(unit_ready), 64'h0);
    chk("reset_wb_valid", 64'(wb_valid), 64'h0);
    chk("reset_pend_busy", 64'(pend_busy), 64'h0);
    chk("reset_conflict_cnt", 64'(conflict_cnt), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[s]) begin
      @(negedge clk);
      drive(vecs[s].vld, vecs[s].clr, vecs[s].fl, vecs[s].rdy);
      #1;
      exp_rd   = vecs[s].exp_valid ? rd_of(int'(vecs[s].exp_unit)) : '0;
      exp_fp   = vecs[s].exp_valid ? fp_of(int'(vecs[s].exp_unit)) : 1'b0;
      exp_data = vecs[s].exp_valid ? data_of(int'(vecs[s].exp_unit)) : '0;
      rd_mask     = '0;
      exp_pend_rd = '0;
      for (int i = 0; i < N; i++) begin
        if (vecs[s].exp_busy[i]) begin
          rd_mask[i*RW +: RW]     = '1;
          exp_pend_rd[i*RW +: RW] = rd_of(i);
        end
      end
      $display("step %0d: wb_valid=%0b wb_unit=%0d wb_rd=%0d wb_data=%08h pend_busy=%03h unit_ready=%03h",
               s, wb_valid, wb_unit, wb_rd, wb_data, pend_busy, unit_ready);
      chk($sformatf("s%0d_wb_valid", s), 64'(wb_valid), 64'(vecs[s].exp_valid));
      chk($sformatf("s%0d_wb_unit", s), 64'(wb_unit), 64'(vecs[s].exp_unit));
      chk($sformatf("s%0d_wb_rd", s), 64'(wb_rd), 64'(exp_rd));
      chk($sformatf("s%0d_wb_is_fp", s), 64'(wb_is_fp), 64'(exp_fp));
      chk($sformatf("s%0d_wb_data", s), 64'(wb_data), 64'(exp_data));
      chk($sformatf("s%0d_pend_busy", s), 64'(pend_busy), 64'(vecs[s].exp_busy));
      chk($sformatf("s%0d_pend_rd", s), 64'(pend_rd & rd_mask), 64'(exp_pend_rd));
      chk($sformatf("s%0d_unit_ready", s), 64'(unit_ready), 64'(vecs[s].exp_ready));
    end
    #1;
    chk("table_conflict_cnt", 64'(conflict_cnt), PERF ? 64'd4 : 64'd0);

    // Asynchronous reset in the middle of a stall; rr_ptr must restart at 0.
    @(negedge clk);
    drive(9'h004, '0, 1'b0, 1'b0);
    @(negedge clk);
    drive('0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("stall_wb_valid", 64'(wb_valid), 64'h1);
    chk("stall_wb_unit", 64'(wb_unit), 64'd2);
    #1;
    reset_n = 1'b0;
    #1;
    $display("async reset: wb_valid=%0b wb_data=%08h pend_busy=%03h unit_ready=%03h",
             wb_valid, wb_data, pend_busy, unit_ready);
    chk("arst_wb_valid", 64'(wb_valid), 64'h0);
    chk("arst_wb_unit", 64'(wb_unit), 64'h0);
    chk("arst_wb_rd", 64'(wb_rd), 64'h0);
    chk("arst_wb_data", 64'(wb_data), 64'h0);
    chk("arst_pend_busy", 64'(pend_busy), 64'h0);
    chk("arst_pend_rd", 64'(pend_rd), 64'h0);
    chk("arst_unit_ready", 64'(unit_ready), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(9'h102, '0, 1'b0, 1'b1);
    @(negedge clk);
    drive('0, '0, 1'b0, 1'b1);
    #1;
    $display("post reset: wb_valid=%0b wb_unit=%0d", wb_valid, wb_unit);
    chk("post_rst_wb_valid", 64'(wb_valid), 64'h1);
    chk("post_rst_rr_grant", 64'(wb_unit), 64'd1);

`ifdef WB_ARB_PERF_CNT_EN
    @(negedge clk);
    reset_n = 1'b0;
    drive('0, '0, 1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    drive(9'h007, '0, 1'b0, 1'b1);
    @(negedge clk);
    drive('0, '0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    $display("perf: conflict_cnt=%0d after three-slot drain", conflict_cnt);
    chk("perf_three_slot", 64'(conflict_cnt), 64'd2);
    drive(9'h003, '0, 1'b0, 1'b0);
    @(negedge clk);
    drive('0, '0, 1'b0, 1'b0);
    repeat (65540) @(negedge clk);
    #1;
    $display("perf: conflict_cnt=%04h after long stall", conflict_cnt);
    chk("perf_saturate", 64'(conflict_cnt), 64'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameters: NUM_UNITS, 9, number of execution units sharing the writeback port; RD_ADDR_WIDTH, 5, rd address bits; DATA_WIDTH, 32, result bits.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush; drops all held results
- unit_valid  in  NUM_UNITS  unit i presents a finished result
- unit_ready  out  NUM_UNITS  unit i result accepted this cycle
- unit_rd  in  NUM_UNITS x RD_ADDR_WIDTH  destination register per unit
- unit_is_fp  in  NUM_UNITS  1 = FP register file, 0 = integer
- unit_data  in  NUM_UNITS x DATA_WIDTH  result per unit
- clear_rd  in  NUM_UNITS  WAW kill of unit i's in-flight result (from clear-units decoder)
- wb_valid  out  1  writeback slot carries a result
- wb_ready  in  1  register file/MEM stage accepts writeback
- wb_unit  out  ceil(log2(NUM_UNITS))  index of granted unit
- wb_rd  out  RD_ADDR_WIDTH  granted destination register
- wb_is_fp  out  1  granted register-file select
- wb_data  out  DATA_WIDTH  granted result
- pend_busy  out  NUM_UNITS  holding slot i valid (feeds all_uu_rd_busy)
- pend_rd  out  NUM_UNITS x RD_ADDR_WIDTH  rd held in slot i
- conflict_cnt  out  16  arbitration-conflict counter (see Configuration)

Function
REQ-003 SHALL hold one result slot per unit (valid, rd, is_fp, data).
REQ-004 SHALL drive unit_ready[i] = ~slot_valid[i] | (grant[i] & wb_ready) & ~flush; capture on unit_valid[i] & unit_ready[i] at rising edge.
REQ-005 SHALL define eligible[i] = slot_valid[i] & ~clear_rd[i]; a cleared slot is never granted in the cycle clear_rd[i] is high.
REQ-006 SHALL grant the first eligible slot scanning rr_ptr, rr_ptr+1, ... wrapping modulo NUM_UNITS; one-hot grant, combinational.
REQ-007 SHALL drive wb_valid = |eligible; wb_unit/wb_rd/wb_is_fp/wb_data from granted slot; all zero when wb_valid=0.
REQ-008 SHALL on wb_valid & wb_ready: invalidate granted slot and set rr_ptr = (granted index + 1) mod NUM_UNITS; index NUM_UNITS-1 wraps to 0.
REQ-009 SHALL hold wb outputs and rr_ptr stable while wb_valid & ~wb_ready unless clear_rd or flush removes the granted slot.
REQ-010 SHALL on clear_rd[i] invalidate slot i at next edge; a same-cycle capture for unit i is also dropped (unit_ready[i] still asserted).
REQ-011 SHALL on flush invalidate all slots at next edge, accept no capture, leave rr_ptr unchanged; flush overrides wb_ready (no slot retired as written).
REQ-012 SHALL provide minimum latency of 1 cycle: result captured at edge N appears on wb_* in cycle N+1; back-to-back results from one unit SHALL sustain 1 per cycle when wb_ready=1 and no other unit is eligible.
REQ-013 SHALL drive pend_busy = slot_valid and pend_rd = slot rd, registered.

Reset
REQ-014 SHALL on reset_n=0 asynchronously clear all slot valids, rr_ptr=0, conflict_cnt=0; unit_ready, wb_valid, wb_* and pend_* read 0 while in reset.
REQ-015 SHALL start accepting results on the first rising edge after reset_n deasserts.

Configuration
REQ-016 SHALL compile the conflict counter only when macro WB_ARB_PERF_CNT_EN is defined: counts cycles with >=2 eligible slots, saturating at 16'hFFFF, cleared by reset only.
REQ-017 SHALL without WB_ARB_PERF_CNT_EN tie conflict_cnt to 16'h0000 with no counter flops.

Verification
REQ-018 Single: unit 3 valid, rd=5, data=32'hDEAD_BEEF, wb_ready=1 -> next cycle wb_valid=1, wb_unit=3, wb_rd=5, wb_data=32'hDEAD_BEEF; rr_ptr=4.
REQ-019 Round robin: units 0,2,8 captured same edge, rr_ptr=0, wb_ready=1 -> grants 0,2,8 on three consecutive cycles, then rr_ptr wraps to 0.
REQ-020 Backpressure: unit 1 held, wb_ready=0 for 4 cycles -> wb_* stable, unit_ready[1]=0; wb_ready=1 -> retired, unit_ready[1]=1.
REQ-021 WAW kill: units 1,2 held, rr_ptr=1, clear_rd[1]=1 one cycle -> unit 2 granted that cycle, slot 1 never written, pend_busy[1]=0 next cycle.
REQ-022 Flush/reset: 5 slots held, flush=1 -> all pend_busy=0 next cycle, no writeback; reset_n pulsed low mid-stall -> outputs 0 immediately, rr_ptr=0.
REQ-023 With WB_ARB_PERF_CNT_EN: 3 eligible slots for 3 cycles -> conflict_cnt=2 (third cycle has 1 eligible); counter preset near 16'hFFFF stays 16'hFFFF.
